fifo_word_to_byte: RTL



---
 rtl/fifo_pkg.sv | 19 +
 rtl/fifo_beat_shifter.sv | 54 +++++
 rtl/fifo_word_to_byte.sv | 108 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO/link widths and beat-shifter operation codes
package fifo_pkg;

  localparam int FIFO_DWIDTH    = 16;
  localparam int LINK_BWIDTH    = 8;
  localparam int BEATS_PER_WORD = FIFO_DWIDTH / LINK_BWIDTH;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_LOAD  = 2'd2,
    SH_CLEAR = 2'd3
  } shift_op_e;

  function automatic int beats_per_word(input int dwidth, input int bwidth);
    return dwidth / bwidth;
  endfunction

endpackage

// File: rtl/fifo_beat_shifter.sv
// rtl/fifo_beat_shifter.sv - word shift register with beats-remaining counter
module fifo_beat_shifter
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = FIFO_DWIDTH,
  parameter int BWIDTH    = LINK_BWIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  shift_op_e         op,
  input  logic [DWIDTH-1:0] load_data,
  output logic [BWIDTH-1:0] beat,
  output logic              valid,
  output logic              last
);

  localparam int R  = beats_per_word(DWIDTH, BWIDTH);
  localparam int CW = $clog2(R + 1);
  localparam logic [CW-1:0] R_CNT = CW'(R);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [DWIDTH-1:0] sh_q;
  logic [CW-1:0]     cnt_q;

  // Load a fresh word, step to the next beat, or drop the remaining beats.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      case (op)
        SH_LOAD: begin
          sh_q  <= load_data;
          cnt_q <= R_CNT;
        end
        SH_SHIFT: begin
          sh_q  <= MSB_FIRST ? (sh_q << BWIDTH) : (sh_q >> BWIDTH);
          cnt_q <= cnt_q - ONE;
        end
        SH_CLEAR: cnt_q <= '0;
        default:  cnt_q <= cnt_q;
      endcase
    end
  end

  // The outgoing beat always sits at the end the shift moves toward.
  always_comb begin
    beat  = MSB_FIRST ? sh_q[DWIDTH-1 -: BWIDTH] : sh_q[BWIDTH-1:0];
    valid = (cnt_q != '0);
    last  = (cnt_q == ONE);
  end

endmodule

// File: rtl/fifo_word_to_byte.sv
// rtl/fifo_word_to_byte.sv - pops FIFO words and streams them as beats
module fifo_word_to_byte
  import fifo_pkg::*;
#(
  parameter int DWIDTH    = FIFO_DWIDTH,
  parameter int BWIDTH    = LINK_BWIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  generate
    if ((DWIDTH % BWIDTH) != 0 || (DWIDTH / BWIDTH) < 2) begin : g_bad_width
      $error("fifo_word_to_byte: DWIDTH must be a multiple of BWIDTH with at least two beats");
    end
  endgenerate

  logic              pend_q;
  logic              nb_vld;
  logic [DWIDTH-1:0] nb_q;
  logic              hs;
  logic              nb_load;
  logic              nb_clr;
  shift_op_e         op;
  logic [DWIDTH-1:0] load_data;

  // A pop is only issued with no read pending and the next buffer free, so the
  // empty flag has settled and the returning word always has somewhere to land.
  always_comb begin
    fifo_rd_en = !fifo_empty && !pend_q && !nb_vld && !flush;
    hs         = m_valid && m_ready;
    busy       = m_valid | nb_vld | pend_q;
  end

  // Remember that the FIFO will present a word on fifo_dout next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pend_q <= 1'b0;
    else       pend_q <= fifo_rd_en;
  end

  // Decide where the returning word goes and how the shifter advances;
  // flush overrides capture and handshake.
  always_comb begin
    op        = SH_HOLD;
    load_data = fifo_dout;
    nb_load   = 1'b0;
    nb_clr    = 1'b0;
    if (flush) begin
      op     = SH_CLEAR;
      nb_clr = 1'b1;
    end else begin
      if (hs && !m_last) begin
        op = SH_SHIFT;
      end else if (hs && m_last) begin
        if (nb_vld) begin
          op        = SH_LOAD;
          load_data = nb_q;
          nb_clr    = 1'b1;
        end else if (pend_q) begin
          op = SH_LOAD;
        end else begin
          op = SH_CLEAR;
        end
      end else if (!m_valid && pend_q) begin
        op = SH_LOAD;
      end
      nb_load = pend_q && m_valid && !(m_last && hs);
    end
  end

  // One-word buffer holding a word that arrived while the shifter was busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nb_vld <= 1'b0;
      nb_q   <= '0;
    end else if (nb_clr) begin
      nb_vld <= 1'b0;
    end else if (nb_load) begin
      nb_vld <= 1'b1;
      nb_q   <= fifo_dout;
    end
  end

  fifo_beat_shifter #(
    .DWIDTH   (DWIDTH),
    .BWIDTH   (BWIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .clk      (clk),
    .rstn     (rstn),
    .op       (op),
    .load_data(load_data),
    .beat     (m_data),
    .valid    (m_valid),
    .last     (m_last)
  );

endmodule
